// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between multicycle_ctrl and the 32-bit datapath.
// Latency: none. The bundle is wires only.
// Backpressure: mem_ready is the only back-channel, and it stalls the controller.
// Ports: opcode/funct/mem_ready flow from the datapath to the controller.
//        Strobes, mux selects and instret flow from the controller to the datapath.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_select;
    logic             illegal_op;
    logic [CNT_W-1:0] instret;

    // Controller side
    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_select, illegal_op, instret
    );

    // Datapath side
    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_select, illegal_op, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (fetch/decode/exec/mem/wb) for the 32-bit datapath, with a retired-instruction counter.
// Latency: beq/j take 3 cycles, R-type/addi/sw take 4, and lw takes 5. Each stall cycle adds 1.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready. mem_ready is ignored in all other states.
// Ports: clk, rst_n (async active-low), and bus (multicycle_ctrl_if.master).
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_ADDI_WB  = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    logic [3:0]       state, state_nxt;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_select;

    always_comb begin
        state_nxt     = state;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_select    = ALU_ADD;
        illegal_op    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;                 // PC + 4
                // The IR latch and the PC advance happen only on the cycle
                // memory delivers. This keeps the PC stable through a stall.
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDI_EX;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only lw/sw reach here, so anything other than lw is sw
                state_nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                state_nxt = S_RTYPE_WB;
                case (bus.funct)
                    FN_ADD:  alu_select = ALU_ADD;
                    FN_SUB:  alu_select = ALU_SUB;
                    FN_AND:  alu_select = ALU_AND;
                    FN_OR:   alu_select = ALU_OR;
                    default: begin
                        illegal_op = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_RTYPE_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                // The zero flag qualifies the PC load in the datapath
                alu_src_a     = 1'b1;
                alu_select    = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                retire        = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_nxt = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;          // unused encodings recover
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instret_q <= instret_q + CNT_W'(1);   // wraps naturally
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_src        = pc_src;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_select    = alu_select;
    assign bus.illegal_op    = illegal_op;
    assign bus.instret       = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl, plus hand sequences for mid-instruction reset and counter wrap.
// Latency: inputs are driven after each falling edge, and outputs are sampled 1 time unit later.
// Backpressure: mem_ready is driven per cycle from the vector table.
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_select, illegal_op}
    logic [17:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_select, bus.illegal_op};

    function automatic logic [17:0] ow(input logic pcw, input logic pcc, input logic [1:0] pcs,
                                       input logic io, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] sel, input logic ill);
        return {pcw, pcc, pcs, io, mr, mw, irw, rd, m2r, rw, sa, sb, sel, ill};
    endfunction

    typedef struct {
        logic [5:0]       op;
        logic [5:0]       fn;
        logic             rdy;
        logic [17:0]      exp;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [17:0] O_FETCH_STALL, O_FETCH_GO, O_DECODE, O_DECODE_ILL, O_MEMADR, O_MEMRD;
    logic [17:0] O_MEMWB, O_MEMWR, O_EXEC_ADD, O_EXEC_SUB, O_EXEC_AND, O_EXEC_OR;
    logic [17:0] O_EXEC_ILL, O_RTYPE_WB, O_BRANCH, O_ADDI_EX, O_ADDI_WB, O_JUMP;

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic [17:0] exp, input int cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.exp = exp; v.cnt = CNT_W'(cnt);
        vecs.push_back(v);
    endtask

    task automatic chk_out(input string name, input logic [17:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", name, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [CNT_W-1:0] exp);
        checks++;
        if (bus.instret !== exp) begin
            errors++;
            $display("FAIL %s instret: got %0d expected %0d", name, bus.instret, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    logic [CNT_W-1:0] exp_cnt;

    initial begin
        //                   pcw pcc pcs  io mr mw irw rd m2r rw sa sb    sel     ill
        O_FETCH_STALL = ow(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 0);
        O_FETCH_GO    = ow(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 0);
        O_DECODE      = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 0);
        O_DECODE_ILL  = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 1);
        O_MEMADR      = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0);
        O_MEMRD       = ow(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0);
        O_MEMWB       = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 0);
        O_MEMWR       = ow(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0);
        O_EXEC_ADD    = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
        O_EXEC_SUB    = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b011, 0);
        O_EXEC_AND    = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 0);
        O_EXEC_OR     = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0);
        O_EXEC_ILL    = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 1);
        O_RTYPE_WB    = ow(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0);
        O_BRANCH      = ow(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b011, 0);
        O_ADDI_EX     = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0);
        O_ADDI_WB     = ow(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 0);
        O_JUMP        = ow(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0);

        // sub, no stalls: 4 cycles
        add(R, 6'b100010, 1, O_FETCH_GO, 0);
        add(R, 6'b100010, 0, O_DECODE,   0);
        add(R, 6'b100010, 0, O_EXEC_SUB, 0);
        add(R, 6'b100010, 1, O_RTYPE_WB, 0);
        // lw with three MEMRD stalls: 8 cycles
        add(LW, 6'd0, 1, O_FETCH_GO, 1);
        add(LW, 6'd0, 1, O_DECODE,   1);
        add(LW, 6'd0, 1, O_MEMADR,   1);
        add(LW, 6'd0, 0, O_MEMRD,    1);
        add(LW, 6'd0, 0, O_MEMRD,    1);
        add(LW, 6'd0, 0, O_MEMRD,    1);
        add(LW, 6'd0, 1, O_MEMRD,    1);
        add(LW, 6'd0, 0, O_MEMWB,    1);
        // FETCH stalled twice, then add
        add(R, 6'b100000, 0, O_FETCH_STALL, 2);
        add(R, 6'b100000, 0, O_FETCH_STALL, 2);
        add(R, 6'b100000, 1, O_FETCH_GO,    2);
        add(R, 6'b100000, 0, O_DECODE,      2);
        add(R, 6'b100000, 0, O_EXEC_ADD,    2);
        add(R, 6'b100000, 0, O_RTYPE_WB,    2);
        // beq, then j: 3 cycles each
        add(BEQ, 6'd0, 1, O_FETCH_GO, 3);
        add(BEQ, 6'd0, 1, O_DECODE,   3);
        add(BEQ, 6'd0, 0, O_BRANCH,   3);
        add(JMP, 6'd0, 1, O_FETCH_GO, 4);
        add(JMP, 6'd0, 0, O_DECODE,   4);
        add(JMP, 6'd0, 1, O_JUMP,     4);
        // illegal opcode, then illegal funct: no retire
        add(BAD, 6'd0, 1, O_FETCH_GO,   5);
        add(BAD, 6'd0, 1, O_DECODE_ILL, 5);
        add(R,   6'd0, 1, O_FETCH_GO,   5);
        add(R,   6'd0, 0, O_DECODE,     5);
        add(R,   6'd0, 0, O_EXEC_ILL,   5);
        // and, or
        add(R, 6'b100100, 1, O_FETCH_GO, 5);
        add(R, 6'b100100, 0, O_DECODE,   5);
        add(R, 6'b100100, 0, O_EXEC_AND, 5);
        add(R, 6'b100100, 0, O_RTYPE_WB, 5);
        add(R, 6'b100101, 1, O_FETCH_GO, 6);
        add(R, 6'b100101, 0, O_DECODE,   6);
        add(R, 6'b100101, 0, O_EXEC_OR,  6);
        add(R, 6'b100101, 0, O_RTYPE_WB, 6);
        // sw with one MEMWR stall
        add(SW, 6'd0, 1, O_FETCH_GO, 7);
        add(SW, 6'd0, 0, O_DECODE,   7);
        add(SW, 6'd0, 0, O_MEMADR,   7);
        add(SW, 6'd0, 0, O_MEMWR,    7);
        add(SW, 6'd0, 1, O_MEMWR,    7);
        // addi
        add(ADDI, 6'd0, 1, O_FETCH_GO, 8);
        add(ADDI, 6'd0, 1, O_DECODE,   8);
        add(ADDI, 6'd0, 1, O_ADDI_EX,  8);
        add(ADDI, 6'd0, 1, O_ADDI_WB,  8);
        // start a sw that is reset mid-flight below
        add(SW, 6'd0, 1, O_FETCH_GO, 9);

        // reset state
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.mem_ready = 1'b0;
        @(negedge clk); #1;
        chk_out("reset_outputs", O_FETCH_STALL);
        chk_cnt("reset_instret", '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.opcode = vecs[i].op; bus.funct = vecs[i].fn; bus.mem_ready = vecs[i].rdy;
            #1;
            chk_out($sformatf("row%0d", i), vecs[i].exp);
            chk_cnt($sformatf("row%0d", i), vecs[i].cnt);
        end

        // sw interrupted by reset while waiting in MEMWR
        @(negedge clk); bus.mem_ready = 1'b1;                       // DECODE
        @(negedge clk);                                              // MEMADR
        @(negedge clk); bus.mem_ready = 1'b0; #1;                    // MEMWR
        chk_bit("memwr_write_before_reset", bus.mem_write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("memwr_write_after_reset", bus.mem_write, 1'b0);
        chk_out("reset_mid_instr_outputs", O_FETCH_STALL);
        chk_cnt("reset_mid_instr_instret", '0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk_out("after_reset_release", O_FETCH_STALL);

        // 16 addi retire with a 4-bit counter, which wraps back to 0
        exp_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                bus.opcode = ADDI; bus.funct = 6'd0; bus.mem_ready = 1'b1;
                #1;
                if (c == 0) chk_cnt($sformatf("addi%0d_start", i), exp_cnt);
                if (c == 3) chk_out($sformatf("addi%0d_wb", i), O_ADDI_WB);
            end
            exp_cnt = exp_cnt + CNT_W'(1);
        end
        @(negedge clk); bus.mem_ready = 1'b0; #1;
        chk_cnt("instret_wrap", exp_cnt);
        chk_cnt("instret_wrap_zero", '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
